// File: rtl/qar_bus_pkg.sv
// qar_bus_pkg: shared definitions for QAR-Core bus responders.
//   - bus_state_t   : responder FSM encoding (IDLE / WAIT / RESP)
//   - rd_src_t      : which source currently drives mem_rdata
//   - bus_req_t     : one latched bus request (we, byte addr, write data)
//   - addr_chk_t    : result of the address checker (fault flag, word index)
//   - qar_addr_check: range/alignment checker, also meant for the future
//                     instruction-memory responder
package qar_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } bus_state_t;

    typedef enum logic [1:0] {
        RD_ZERO = 2'd0,
        RD_RAM  = 2'd1,
        RD_ERR  = 2'd2
    } rd_src_t;

    localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } bus_req_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] word;   // word offset from base, full width
    } addr_chk_t;

    // The subtraction is 33 bits wide so an address below the base shows up
    // as a borrow instead of wrapping to a large in-range-looking offset.
    function automatic addr_chk_t qar_addr_check(input logic [31:0] addr,
                                                 input logic [31:0] base,
                                                 input logic [31:0] depth);
        logic [32:0] diff;
        addr_chk_t   r;
        diff    = {1'b0, addr} - {1'b0, base};
        r.word  = {2'b00, diff[31:2]};
        r.fault = (addr[1:0] != 2'b00) || diff[32] || (r.word >= depth);
        return r;
    endfunction

endpackage

// File: rtl/qar_sram_1rw.sv
// qar_sram_1rw: single-port synchronous RAM, DEPTH x 32.
// One write or one read per enabled cycle; the read result is registered and
// holds until the next enabled read. Contents are never reset.
//   clk   : clock
//   en    : access enable
//   we    : 1 = write wdata to addr, 0 = read addr into rdata
//   addr  : word index
//   wdata : write data
//   rdata : registered read data
module qar_sram_1rw #(
    parameter int DEPTH      = 256,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/qar_dmem_responder.sv
// qar_dmem_responder: responder end of the QAR-Core data-memory bus.
// Word-addressed SRAM with programmable wait states, alignment/range checks
// and error reporting.
//   clk, rst   : clock, asynchronous active-high reset
//   mem_valid  : request valid, held by the initiator until mem_ready
//   mem_we     : 1 = write, 0 = read
//   mem_addr   : byte address
//   mem_wdata  : write data
//   mem_ready  : one-cycle completion pulse
//   mem_rdata  : read data, valid with mem_ready, held otherwise
//   err_pulse  : pulses with mem_ready on a faulted access
//   err_addr   : address of the most recent faulted access
//   busy       : FSM not idle
module qar_dmem_responder
    import qar_bus_pkg::*;
#(
    parameter int          DEPTH       = 256,
    parameter int          ADDR_WIDTH  = 8,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ERR_DATA    = DEFAULT_ERR_DATA
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        err_pulse,
    output logic [31:0] err_addr,
    output logic        busy
);

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    bus_state_t            state;
    logic [3:0]            wait_cnt;
    bus_req_t              req_q;
    bus_req_t              req_live;
    bus_req_t              req_cur;
    addr_chk_t             chk;
    rd_src_t               rd_src;
    logic                  enter_resp;
    logic                  ram_en;
    logic [31:0]           ram_rdata;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic                  unused_idx_hi;

    assign req_live = '{we: mem_we, addr: mem_addr, wdata: mem_wdata};

    // With zero wait states the RESP edge is the acceptance edge itself, so
    // the live bus must feed the checker and RAM; otherwise the latched copy.
    assign req_cur = (state == ST_IDLE) ? req_live : req_q;

    assign chk           = qar_addr_check(req_cur.addr, BASE_ADDR, 32'(DEPTH));
    assign ram_idx       = chk.word[ADDR_WIDTH-1:0];
    assign unused_idx_hi = ^chk.word[31:ADDR_WIDTH];

    // The coming edge completes the access (and touches the RAM).
    always_comb begin
        enter_resp = 1'b0;
        if (mem_valid) begin
            case (state)
                ST_IDLE: enter_resp = (WAIT_STATES == 0);
                ST_WAIT: enter_resp = (wait_cnt == 4'd0);
                default: enter_resp = 1'b0;
            endcase
        end
    end

    // rst gates the RAM so an edge during reset can never commit a write.
    assign ram_en = enter_resp && !chk.fault && !rst;

    qar_sram_1rw #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk   (clk),
        .en    (ram_en),
        .we    (req_cur.we),
        .addr  (ram_idx),
        .wdata (req_cur.wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            req_q     <= '0;
            mem_ready <= 1'b0;
            err_pulse <= 1'b0;
            err_addr  <= 32'd0;
            busy      <= 1'b0;
            rd_src    <= RD_ZERO;
        end else begin
            mem_ready <= 1'b0;
            err_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_valid) begin
                        req_q <= req_live;
                        busy  <= 1'b1;
                        if (WAIT_STATES == 0) begin
                            state <= ST_RESP;
                        end else begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    // Initiator withdrew: abort silently, nothing committed.
                    if (!mem_valid) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (wait_cnt == 4'd0) begin
                        state <= ST_RESP;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                default: begin
                    // RESP (or an illegal code): always back to idle, a
                    // still-asserted mem_valid here is the request just served.
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase

            if (enter_resp) begin
                mem_ready <= 1'b1;
                err_pulse <= chk.fault;
                if (chk.fault) begin
                    err_addr <= req_cur.addr;
                end
                if (!req_cur.we) begin
                    rd_src <= chk.fault ? RD_ERR : RD_RAM;
                end
            end
        end
    end

    // The RAM output register only moves on an enabled read, so selecting it
    // keeps mem_rdata stable outside RESP and across writes.
    always_comb begin
        mem_rdata = 32'd0;
        case (rd_src)
            RD_RAM:  mem_rdata = ram_rdata;
            RD_ERR:  mem_rdata = ERR_DATA;
            default: mem_rdata = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_qar_dmem_responder.sv
module tb_qar_dmem_responder;

    localparam int NDUT  = 4;
    localparam int DEPTH = 256;
    // DUT 0: WS=1, DUT 1: WS=0, DUT 2: WS=3, DUT 3: WS=1 with base 0x1000
    localparam logic [3:0][3:0]  WS_T   = {4'd1, 4'd3, 4'd0, 4'd1};
    localparam logic [3:0][31:0] BASE_T = {32'h0000_1000, 32'h0, 32'h0, 32'h0};
    localparam logic [31:0]      ERRD   = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [NDUT-1:0] rst, valid, we, ready, errp, busy;
    logic [31:0]     addr [NDUT];
    logic [31:0]     wdata[NDUT];
    logic [31:0]     rdata[NDUT];
    logic [31:0]     erra [NDUT];

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        qar_dmem_responder #(
            .DEPTH       (DEPTH),
            .ADDR_WIDTH  (8),
            .WAIT_STATES (int'(WS_T[g])),
            .BASE_ADDR   (BASE_T[g]),
            .ERR_DATA    (ERRD)
        ) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .mem_valid (valid[g]),
            .mem_we    (we[g]),
            .mem_addr  (addr[g]),
            .mem_wdata (wdata[g]),
            .mem_ready (ready[g]),
            .mem_rdata (rdata[g]),
            .err_pulse (errp[g]),
            .err_addr  (erra[g]),
            .busy      (busy[g])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // age = edges since acceptance (-1 when no request outstanding).
    // The ready cycle is age == WS; the following edge ends the access.
    int          age  [NDUT];
    logic        p_we [NDUT];
    logic [31:0] p_adr[NDUT];
    logic [31:0] p_wd [NDUT];
    logic [31:0] m_mem[NDUT][DEPTH];
    logic        e_rdy[NDUT];
    logic        e_err[NDUT];
    logic [31:0] e_rd [NDUT];
    logic [31:0] e_ea [NDUT];

    task automatic complete(input int k);
        longint a, b, off;
        bit     fault;
        a     = longint'(p_adr[k]);
        b     = longint'(BASE_T[k]);
        off   = a - b;
        fault = (a % 4 != 0) || (off < 0) || (off / 4 >= DEPTH);
        e_rdy[k] = 1'b1;
        e_err[k] = fault;
        if (fault) begin
            e_ea[k] = p_adr[k];
            if (!p_we[k]) e_rd[k] = ERRD;
        end else if (p_we[k]) begin
            m_mem[k][off / 4] = p_wd[k];
        end else begin
            e_rd[k] = m_mem[k][off / 4];
        end
    endtask

    // Apply the effect of the coming clock edge using the inputs it will see.
    task automatic step(input int k);
        int ws;
        ws = int'(WS_T[k]);
        e_rdy[k] = 1'b0;
        e_err[k] = 1'b0;
        if (age[k] < 0) begin
            if (valid[k]) begin
                p_we[k]  = we[k];
                p_adr[k] = addr[k];
                p_wd[k]  = wdata[k];
                age[k]   = 0;
                if (ws == 0) complete(k);
            end
        end else if (age[k] == ws) begin
            age[k] = -1;
        end else if (!valid[k]) begin
            age[k] = -1;
        end else begin
            age[k]++;
            if (age[k] == ws) complete(k);
        end
    endtask

    initial begin
        for (int k = 0; k < NDUT; k++) begin
            age[k] = -1; e_rdy[k] = 0; e_err[k] = 0; e_rd[k] = 0; e_ea[k] = 0;
        end
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int k = 0; k < NDUT; k++) begin
                if (rst[k]) begin
                    age[k] = -1; e_rdy[k] = 0; e_err[k] = 0; e_rd[k] = 0; e_ea[k] = 0;
                end
                chk($sformatf("d%0d ready", k), 32'(ready[k]), 32'(e_rdy[k]));
                chk($sformatf("d%0d err_pulse", k), 32'(errp[k]), 32'(e_err[k]));
                chk($sformatf("d%0d busy", k), 32'(busy[k]), 32'(age[k] >= 0));
                chk($sformatf("d%0d rdata", k), rdata[k], e_rd[k]);
                chk($sformatf("d%0d err_addr", k), erra[k], e_ea[k]);
                if (!rst[k]) step(k);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full access: returns cycles to ready, data/err at ready, busy at ready
    // and busy one cycle later. Bus fields are scrambled once accepted.
    task automatic xact(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rd, output logic ep,
                        output logic b1, output logic b2);
        valid[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
        lat = 0;
        do begin
            tick();
            lat++;
            if (!ready[k]) begin
                we[k] = ~w; addr[k] = ~a; wdata[k] = ~d;
            end
        end while (!ready[k] && lat < 40);
        if (!ready[k]) chk($sformatf("d%0d ready timeout", k), 32'(ready[k]), 32'd1);
        rd = rdata[k]; ep = errp[k]; b1 = busy[k];
        valid[k] = 1'b0; we[k] = 1'b0;
        tick();
        b2 = busy[k];
    endtask

    int          lat;
    logic [31:0] rd;
    logic        ep, b1, b2;

    initial begin
        valid = '0; we = '0; rst = '0;
        for (int k = 0; k < NDUT; k++) begin addr[k] = '0; wdata[k] = '0; end
        #1 rst = '1;
        repeat (3) tick();
        rst = '0;
        tick();
        chk("reset ready", 32'(ready[0]), 32'd0);
        chk("reset busy", 32'(busy[0]), 32'd0);
        chk("reset rdata", rdata[0], 32'd0);
        chk("reset err_addr", erra[0], 32'd0);

        // WS=1 write then read
        xact(0, 1'b1, 32'h10, 32'h1234_5678, lat, rd, ep, b1, b2);
        chk("ws1 wr latency", 32'(lat), 32'd2);
        chk("ws1 wr err", 32'(ep), 32'd0);
        xact(0, 1'b0, 32'h10, 32'h0, lat, rd, ep, b1, b2);
        chk("ws1 rd latency", 32'(lat), 32'd2);
        chk("ws1 rd data", rd, 32'h1234_5678);
        chk("ws1 rd err", 32'(ep), 32'd0);

        // WS=0 preload and back-to-back reads
        xact(1, 1'b1, 32'h0, 32'hA, lat, rd, ep, b1, b2);
        xact(1, 1'b1, 32'h4, 32'hB, lat, rd, ep, b1, b2);
        xact(1, 1'b0, 32'h0, 32'h0, lat, rd, ep, b1, b2);
        chk("ws0 rd0 latency", 32'(lat), 32'd1);
        chk("ws0 rd0 data", rd, 32'hA);
        chk("ws0 rd0 busy", {30'd0, b1, b2}, 32'b10);
        xact(1, 1'b0, 32'h4, 32'h0, lat, rd, ep, b1, b2);
        chk("ws0 rd4 latency", 32'(lat), 32'd1);
        chk("ws0 rd4 data", rd, 32'hB);
        chk("ws0 rd4 busy", {30'd0, b1, b2}, 32'b10);

        // faults: misaligned, out of range, dropped write
        xact(1, 1'b0, 32'h402, 32'h0, lat, rd, ep, b1, b2);
        chk("misalign data", rd, 32'hDEAD_BEEF);
        chk("misalign err", 32'(ep), 32'd1);
        xact(1, 1'b0, 32'h400, 32'h0, lat, rd, ep, b1, b2);
        chk("range data", rd, 32'hDEAD_BEEF);
        chk("range err", 32'(ep), 32'd1);
        chk("range err_addr", erra[1], 32'h400);
        xact(1, 1'b1, 32'h400, 32'h77, lat, rd, ep, b1, b2);
        chk("range wr err", 32'(ep), 32'd1);
        xact(1, 1'b0, 32'h0, 32'h0, lat, rd, ep, b1, b2);
        chk("no alias data", rd, 32'hA);
        chk("no alias err", 32'(ep), 32'd0);

        // WS=3 abort after one wait cycle
        xact(2, 1'b1, 32'h20, 32'h5555_0020, lat, rd, ep, b1, b2);
        chk("ws3 latency", 32'(lat), 32'd4);
        valid[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h20; wdata[2] = 32'hCAFE;
        tick();
        tick();
        valid[2] = 1'b0;
        tick();
        chk("abort ready", 32'(ready[2]), 32'd0);
        chk("abort busy", 32'(busy[2]), 32'd0);
        tick();
        xact(2, 1'b0, 32'h20, 32'h0, lat, rd, ep, b1, b2);
        chk("abort old data", rd, 32'h5555_0020);

        // base 0x1000
        xact(3, 1'b1, 32'h0000_0FFC, 32'h1, lat, rd, ep, b1, b2);
        chk("below base err", 32'(ep), 32'd1);
        xact(3, 1'b0, 32'hFFFF_FFFC, 32'h0, lat, rd, ep, b1, b2);
        chk("wrap err", 32'(ep), 32'd1);
        chk("wrap data", rd, 32'hDEAD_BEEF);
        chk("wrap err_addr", erra[3], 32'hFFFF_FFFC);
        xact(3, 1'b1, 32'h0000_1000, 32'h0000_0001, lat, rd, ep, b1, b2);
        xact(3, 1'b1, 32'h0000_13FC, 32'h600D_13FC, lat, rd, ep, b1, b2);
        chk("top word wr err", 32'(ep), 32'd0);
        xact(3, 1'b0, 32'h0000_13FC, 32'h0, lat, rd, ep, b1, b2);
        chk("top word data", rd, 32'h600D_13FC);
        chk("top word err", 32'(ep), 32'd0);

        // reset during WAIT of a write
        xact(0, 1'b1, 32'h8, 32'h0808_0808, lat, rd, ep, b1, b2);
        valid[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h8; wdata[0] = 32'h0000_0BAD;
        tick();
        chk("pre-reset busy", 32'(busy[0]), 32'd1);
        rst[0] = 1'b1;
        #1;
        chk("mid reset ready", 32'(ready[0]), 32'd0);
        chk("mid reset busy", 32'(busy[0]), 32'd0);
        valid[0] = 1'b0; we[0] = 1'b0;
        tick();
        tick();
        rst[0] = 1'b0;
        tick();
        xact(0, 1'b0, 32'h8, 32'h0, lat, rd, ep, b1, b2);
        chk("post reset data", rd, 32'h0808_0808);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
